// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered long-latency results.
// Provides WAW ordering, x0 suppression and a starvation guard for the FIFO head.
module wb_port_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ce,
    input  logic        i_pipe_wr_en,
    input  logic [4:0]  i_pipe_rd_addr,
    input  logic [31:0] i_pipe_rd,
    output logic        o_stall,
    input  logic        i_mc_valid,
    input  logic [4:0]  i_mc_rd_addr,
    input  logic [31:0] i_mc_rd,
    output logic        o_mc_ready,
    output logic        o_wr_en,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd,
    output logic        o_mc_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [4:0]       q_addr [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [DEPTH-1:0] q_vld;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic [CW-1:0]    starve_cnt;

    logic full;
    logic empty;
    logic pipe_req;
    logic fifo_req;
    logic waw_hit;
    logic enq;
    logic grant_fifo;
    logic grant_pipe;

    assign full       = (count == (AW+1)'(DEPTH));
    assign empty      = (count == '0);
    assign o_mc_ready = !full;
    assign pipe_req   = i_ce && i_pipe_wr_en && (i_pipe_rd_addr != 5'd0);
    assign fifo_req   = !empty;
    assign enq        = i_mc_valid && !full && (i_mc_rd_addr != 5'd0);
    assign count_next = count + (AW+1)'(enq) - (AW+1)'(grant_fifo);

    // Any pending result to the same rd must land before the younger pipeline write.
    always_comb begin
        waw_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_vld[i] && (q_addr[i] == i_pipe_rd_addr))
                waw_hit = 1'b1;
        end
        waw_hit = waw_hit && pipe_req;
    end

    always_comb begin
        grant_fifo = 1'b0;
        grant_pipe = 1'b0;
        o_stall    = 1'b0;
        if (fifo_req && (starve_cnt == CW'(STARVE_MAX))) begin
            grant_fifo = 1'b1;
            o_stall    = pipe_req;
        end else if (waw_hit) begin
            grant_fifo = 1'b1;
            o_stall    = 1'b1;
        end else if (pipe_req) begin
            grant_pipe = 1'b1;
        end else if (fifo_req) begin
            grant_fifo = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (enq) begin
            q_addr[wr_ptr] <= i_mc_rd_addr;
            q_data[wr_ptr] <= i_mc_rd;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            q_vld      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            o_mc_busy  <= 1'b0;
            o_wr_en    <= 1'b0;
            o_rd_addr  <= 5'd0;
            o_rd       <= 32'd0;
        end else begin
            if (grant_fifo) begin
                q_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + AW'(1);
            end
            if (enq) begin
                q_vld[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + AW'(1);
            end
            count     <= count_next;
            o_mc_busy <= (count_next != '0);

            if (empty || grant_fifo)
                starve_cnt <= '0;
            else if (starve_cnt != CW'(STARVE_MAX))
                starve_cnt <= starve_cnt + CW'(1);

            o_wr_en <= grant_fifo || grant_pipe;
            if (grant_fifo) begin
                o_rd_addr <= q_addr[rd_ptr];
                o_rd      <= q_data[rd_ptr];
            end else if (grant_pipe) begin
                o_rd_addr <= i_pipe_rd_addr;
                o_rd      <= i_pipe_rd;
            end
        end
    end

endmodule
